// File: rtl/pcs_10g_pkg.sv
// Shared 10GBASE-R PCS definitions: block geometry, sync headers, scrambler seed and
// the unrolled G(x) = 1 + x^39 + x^58 payload scrambler.
package pcs_10g_pkg;

  localparam int unsigned BLOCK_W     = 66;
  localparam int unsigned PAYLOAD_W   = 64;
  localparam int unsigned SCR_STATE_W = 58;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [SCR_STATE_W-1:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    BufEmpty,
    BufOne,
    BufTwo
  } buf_state_e;

  typedef struct packed {
    logic [SCR_STATE_W-1:0] state;
    logic [PAYLOAD_W-1:0]   data;
  } scr_res_t;

  function automatic logic hdr_invalid(input logic [1:0] hdr);
    return !((hdr == SYNC_DATA) || (hdr == SYNC_CTRL));
  endfunction

  // s[j] is the line bit at time j-58: s[57:0] is the history (h reversed in time),
  // s[121:58] is the new scrambled payload. Each output bit taps s[i] and s[i+19].
  function automatic scr_res_t scramble(input logic [SCR_STATE_W-1:0] h,
                                        input logic [PAYLOAD_W-1:0]   d);
    logic [SCR_STATE_W+PAYLOAD_W-1:0] s;
    scr_res_t                         res;
    s = '0;
    for (int k = 0; k < SCR_STATE_W; k++) begin
      s[SCR_STATE_W-1-k] = h[k];
    end
    for (int i = 0; i < PAYLOAD_W; i++) begin
      s[SCR_STATE_W+i] = d[i] ^ s[i+19] ^ s[i];
    end
    res.data = s[SCR_STATE_W+PAYLOAD_W-1:SCR_STATE_W];
    for (int k = 0; k < SCR_STATE_W; k++) begin
      res.state[k] = s[SCR_STATE_W+PAYLOAD_W-1-k];
    end
    return res;
  endfunction

endpackage

// File: rtl/pcs_10g_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: registered ready and valid, no combinational
// path from ready_i to ready_o.
module pcs_10g_skid_buf
  import pcs_10g_pkg::*;
#(
  parameter int unsigned W = BLOCK_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  input  logic         ready_i
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;
  logic         valid_q, valid_d;
  logic         ready_q, ready_d;
  logic         acc, drn;

  assign acc = valid_i && ready_q;
  assign drn = valid_q && ready_i;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      BufEmpty: begin
        if (acc) begin
          out_d   = data_i;
          state_d = BufOne;
        end
      end
      BufOne: begin
        if (acc && drn) begin
          out_d = data_i;
        end else if (acc) begin
          skid_d  = data_i;
          state_d = BufTwo;
        end else if (drn) begin
          state_d = BufEmpty;
        end
      end
      BufTwo: begin
        if (drn) begin
          out_d   = skid_q;
          state_d = BufOne;
        end
      end
      default: state_d = BufEmpty;
    endcase
    valid_d = (state_d != BufEmpty);
    ready_d = (state_d != BufTwo);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BufEmpty;
      out_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o = ready_q;
  assign data_o  = out_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pcs_10g_tx_scrambler.sv
// 64B/66B TX self-synchronous scrambler feeding the gearbox through a skid buffer.
// Optional per-block scrambler bypass port when PCS_TX_SCR_BYPASS_EN is defined.
module pcs_10g_tx_scrambler
  import pcs_10g_pkg::*;
#(
  parameter logic [SCR_STATE_W-1:0] SEED = SCR_SEED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] tx_block,
  output logic               tx_block_valid,
  input  logic               tx_ready,
`ifdef PCS_TX_SCR_BYPASS_EN
  input  logic               scr_bypass,
`endif
  output logic [15:0]        hdr_err_cnt
);

  logic [SCR_STATE_W-1:0] h_q, h_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [BLOCK_W-1:0]     blk;
  scr_res_t               scr;
  logic                   accept;
  logic                   bypass;

`ifdef PCS_TX_SCR_BYPASS_EN
  assign bypass = scr_bypass;
`else
  assign bypass = 1'b0;
`endif

  assign accept = in_valid && in_ready;
  assign scr    = scramble(h_q, in_block[PAYLOAD_W-1:0]);

  // Header bypasses the scrambler and never enters the history.
  always_comb begin
    blk   = {in_block[BLOCK_W-1:PAYLOAD_W], bypass ? in_block[PAYLOAD_W-1:0] : scr.data};
    h_d   = (accept && !bypass) ? scr.state : h_q;
    cnt_d = cnt_q;
    if (accept && hdr_invalid(in_block[BLOCK_W-1:PAYLOAD_W]) && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q   <= SEED;
      cnt_q <= '0;
    end else begin
      h_q   <= h_d;
      cnt_q <= cnt_d;
    end
  end

  assign hdr_err_cnt = cnt_q;

  pcs_10g_skid_buf #(
    .W(BLOCK_W)
  ) u_skid (
    .clk_i   (clk),
    .rst_i   (rst),
    .data_i  (blk),
    .valid_i (in_valid),
    .ready_o (in_ready),
    .data_o  (tx_block),
    .valid_o (tx_block_valid),
    .ready_i (tx_ready)
  );

endmodule

// File: tb/tb_pcs_10g_tx_scrambler.sv
// Self-checking bench for pcs_10g_tx_scrambler: directed vectors on a zero-seed instance,
// scoreboard against a bit-serial scrambler model on a default-seed instance.
module tb_pcs_10g_tx_scrambler;

  localparam logic [57:0] DEF_SEED = 58'h3FF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // Default-seed instance
  logic [65:0] in_block = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [65:0] tx_block;
  logic        tx_block_valid;
  logic        tx_ready = 1'b1;
  logic [15:0] hdr_err_cnt;
`ifdef PCS_TX_SCR_BYPASS_EN
  logic        scr_bypass = 1'b0;
  logic        z_bypass = 1'b0;
`endif

  // Zero-seed instance
  logic [65:0] z_block = '0;
  logic        z_valid = 1'b0;
  logic        z_in_ready;
  logic [65:0] z_tx_block;
  logic        z_tx_valid;
  logic [15:0] z_cnt;

  pcs_10g_tx_scrambler dut (
    .clk            (clk),
    .rst            (rst),
    .in_block       (in_block),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .tx_block       (tx_block),
    .tx_block_valid (tx_block_valid),
    .tx_ready       (tx_ready),
`ifdef PCS_TX_SCR_BYPASS_EN
    .scr_bypass     (scr_bypass),
`endif
    .hdr_err_cnt    (hdr_err_cnt)
  );

  pcs_10g_tx_scrambler #(
    .SEED(58'h0)
  ) dut_z (
    .clk            (clk),
    .rst            (rst),
    .in_block       (z_block),
    .in_valid       (z_valid),
    .in_ready       (z_in_ready),
    .tx_block       (z_tx_block),
    .tx_block_valid (z_tx_valid),
    .tx_ready       (1'b1),
`ifdef PCS_TX_SCR_BYPASS_EN
    .scr_bypass     (z_bypass),
`endif
    .hdr_err_cnt    (z_cnt)
  );

  int          n_total = 0;
  int          n_fail  = 0;
  logic [65:0] sb[$];
  logic [57:0] mh = DEF_SEED;
  logic [15:0] mcnt = '0;
  bit          armed = 1'b0;
  bit          rnd = 1'b0;

  task automatic check66(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) tx_ready = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send(input logic [65:0] b);
    bit ok = 1'b0;
    in_block = b;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    check1("send_accept_timeout", ok, 1'b1);
  endtask

  task automatic drain();
    tx_ready = 1'b1;
    for (int n = 0; n < 50 && sb.size() != 0; n++) tick();
    check1("drain_empty", sb.size() == 0, 1'b1);
  endtask

  // Bit-serial reference model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      logic [63:0] d;
      logic        o;
      logic        byp;
      if (armed) begin
        check1("in_ready_vs_held", in_ready, sb.size() < 2);
        check1("valid_vs_held", tx_block_valid, sb.size() != 0);
      end
      if (tx_block_valid && tx_ready) begin
        if (sb.size() == 0) begin
          check66("unexpected_block", tx_block, 66'h0);
        end else begin
          check66("tx_block", tx_block, sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        d = in_block[63:0];
        byp = 1'b0;
`ifdef PCS_TX_SCR_BYPASS_EN
        byp = scr_bypass;
`endif
        if (!byp) begin
          for (int i = 0; i < 64; i++) begin
            o    = d[i] ^ mh[38] ^ mh[57];
            d[i] = o;
            mh   = {mh[56:0], o};
          end
        end
        sb.push_back({in_block[65:64], d});
        if ((in_block[65:64] == 2'b00 || in_block[65:64] == 2'b11) && mcnt != 16'hFFFF)
          mcnt = mcnt + 16'd1;
      end
    end
  end

  task automatic do_reset();
    rst   = 1'b1;
    armed = 1'b0;
    sb.delete();
    mh    = DEF_SEED;
    mcnt  = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    armed = 1'b1;
  endtask

  initial begin
    logic [1:0] hdrs[3];
    hdrs[0] = 2'b01; hdrs[1] = 2'b10; hdrs[2] = 2'b01;

    // Reset values while rst is held
    tick();
    check66("rst_tx_block", tx_block, 66'h0);
    check1("rst_tx_valid", tx_block_valid, 1'b0);
    check1("rst_in_ready", in_ready, 1'b0);
    check16("rst_hdr_cnt", hdr_err_cnt, 16'h0);
    rst = 1'b0;
    tick();
    check1("in_ready_after_rst", z_in_ready, 1'b1);

    // Zero-seed single-bit vector
    z_block = {2'b01, 64'h1};
    z_valid = 1'b1;
    tick();
    z_valid = 1'b0;
    check1("z_valid_latency", z_tx_valid, 1'b1);
    check66("z_single_bit", z_tx_block, {2'b01, 64'h0400_0080_0000_0001});

    // Zero-seed zero payloads
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      z_block = {hdrs[k], 64'h0};
      z_valid = 1'b1;
      tick();
      check66("z_zero_payload", z_tx_block, {hdrs[k], 64'h0});
    end
    z_valid = 1'b0;

    // Header error counting
    do_reset();
    send({2'b00, 64'h1234_5678_9ABC_DEF0});
    send({2'b11, 64'hFFFF_0000_FFFF_0000});
    send({2'b01, 64'h0});
    send({2'b10, 64'hDEAD_BEEF_CAFE_F00D});
    drain();
    check16("hdr_err_cnt_2", hdr_err_cnt, 16'd2);

    // Random stream with 25% gearbox duty
    rnd = 1'b1;
    for (int k = 0; k < 1000; k++) send({$urandom_range(0, 3) == 0 ? 2'b00 : 2'b01,
                                          $urandom, $urandom});
    rnd = 1'b0;
    drain();
    check16("hdr_err_cnt_random", hdr_err_cnt, mcnt);

`ifdef PCS_TX_SCR_BYPASS_EN
    // Bypass a block mid-stream
    send({2'b01, 64'h0123_4567_89AB_CDEF});
    scr_bypass = 1'b1;
    send({2'b10, 64'h5555_AAAA_5555_AAAA});
    scr_bypass = 1'b0;
    send({2'b01, 64'hFEDC_BA98_7654_3210});
    drain();
`endif

    // Async reset while two blocks are held
    tx_ready = 1'b0;
    send({2'b01, 64'hAAAA_AAAA_AAAA_AAAA});
    send({2'b01, 64'h5555_5555_5555_5555});
    check1("in_ready_two_held", in_ready, 1'b0);
    #2;
    rst   = 1'b1;
    armed = 1'b0;
    #1;
    check1("mid_rst_tx_valid", tx_block_valid, 1'b0);
    check1("mid_rst_in_ready", in_ready, 1'b0);
    check66("mid_rst_tx_block", tx_block, 66'h0);
    sb.delete();
    mh   = DEF_SEED;
    mcnt = '0;
    tick();
    rst = 1'b0;
    tick();
    armed = 1'b1;
    check1("in_ready_post_rst", in_ready, 1'b1);
    tx_ready = 1'b1;
    send({2'b01, 64'h0F0F_0F0F_0F0F_0F0F});
    drain();

    // Counter saturation
    for (int k = 0; k < 65534; k++) send({2'b11, 64'h0});
    drain();
    check16("hdr_cnt_fffe", hdr_err_cnt, 16'hFFFE);
    send({2'b00, 64'h0});
    drain();
    check16("hdr_cnt_ffff", hdr_err_cnt, 16'hFFFF);
    for (int k = 0; k < 3; k++) send({2'b00, 64'h0});
    drain();
    check16("hdr_cnt_saturated", hdr_err_cnt, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_total, n_fail);
    $finish;
  end

endmodule

// File: doc/pcs_10g_tx_scrambler.md
# pcs_10g_tx_scrambler

Self-synchronous 64B/66B TX scrambler (G(x) = 1 + x^39 + x^58) that sits directly upstream of the TX gearbox. It accepts encoded 66-bit blocks from the 64B/66B encoder and scrambles the 64-bit payload. It passes the 2-bit sync header through unchanged. Output is delivered on a registered valid/ready interface whose ready input is driven by the gearbox's `tx_ready`. A 2-entry skid buffer absorbs gearbox back-pressure without a combinational ready path to the encoder.

## Interface
- SEED, 58'h3FF_FFFF_FFFF_FFFF, scrambler state value loaded at reset
- clk  in  1  644 MHz PCS TX clock
- rst  in  1  asynchronous reset, active-high
- in_block  in  66  encoded block; [65:64] sync header, [63:0] payload, bit 0 first on line
- in_valid  in  1  in_block valid
- in_ready  out  1  block accepted when in_valid && in_ready; registered
- tx_block  out  66  scrambled block to gearbox
- tx_block_valid  out  1  tx_block valid; registered
- tx_ready  in  1  gearbox can accept; transfer when tx_block_valid && tx_ready
- hdr_err_cnt  out  16  saturating count of accepted blocks with header 2'b00 or 2'b11
- scr_bypass  in  1  present only with PCS_TX_SCR_BYPASS_EN (see Configuration)

## Operation
- Scrambling is applied at acceptance, so the state advances only on an input transfer.
- State h[57:0] is held; h[k] is the scrambled bit emitted k+1 bits earlier.
- For i = 0..63 in order: out[i] = in[i] ^ h[38] ^ h[57], then h = {h[56:0], out[i]}.
- The state after bit 63 is registered.
- Header [65:64] is forwarded unscrambled and never enters the state.
- Invalid headers (00/11) are still scrambled and forwarded. hdr_err_cnt increments by 1 per such accepted block and saturates at 16'hFFFF.
- Buffering: output register (OUT) plus skid register (SKID). States:
  - EMPTY → ONE on accept.
  - ONE → EMPTY on drain without accept.
  - ONE → TWO on accept while OUT is stalled.
  - TWO → ONE on drain; SKID moves into OUT.
- in_ready = (state != TWO). A simultaneous accept and drain in ONE stays ONE; OUT is loaded with the new block.
- Order is strictly preserved. No block is dropped or duplicated.
- Reset (asynchronous, any time, including mid-stall):
  - tx_block = 0, tx_block_valid = 0, in_ready = 0
  - hdr_err_cnt = 0, h = SEED, buffer EMPTY
- in_ready rises in the first cycle after rst deasserts. In-flight blocks are discarded.

## Timing
- Latency: a block accepted at edge N presents tx_block_valid = 1 after edge N (visible in cycle N+1).
- Sustained throughput is 1 block/cycle while tx_ready = 1. In practice the gearbox accepts about 1 block per 4 cycles.
- tx_block/tx_block_valid hold stable while tx_block_valid && !tx_ready.
- in_ready deasserts in the cycle after the second unconsumed block is accepted. It reasserts the cycle after a drain from TWO.
- hdr_err_cnt updates one cycle after the accepting edge.
- The 64-bit unrolled XOR is at most 3 levels deep per bit. Keep it in a single cycle at 644 MHz; no extra pipeline stage is permitted.

## Configuration
- PCS_TX_SCR_BYPASS_EN defined: the scr_bypass port exists.
  - When scr_bypass = 1 at acceptance, the payload is forwarded unscrambled and h is frozen.
  - Toggling scr_bypass takes effect per accepted block.
- PCS_TX_SCR_BYPASS_EN undefined: no port; every block is scrambled.

## Structure
- Shared package pcs_10g_pkg holds:
  - SYNC_DATA = 2'b01, SYNC_CTRL = 2'b10
  - BLOCK_W = 66, SCR_STATE_W = 58
  - default SCR_SEED
- Sub-module pcs_10g_skid_buf: generic 2-entry valid/ready skid buffer, width parameter W = 66.
- Scrambler datapath and counter live in the top module.

## Test plan
- SEED = 0, in_block = {2'b01, 64'h1}, tx_ready = 1 → tx_block = {2'b01, 64'h0400_0080_0000_0001} one cycle later.
- SEED = 0, zero payloads ×3 → all outputs payload 0, header unchanged.
- Default SEED: 1000 random blocks with tx_ready toggled randomly (25% duty) → output sequence matches the bit-serial model and has no loss, duplication or reordering. in_ready falls only when two blocks are held.
- Headers 00, 11, 01, 10 each accepted once → hdr_err_cnt = 2. Preload near saturation by streaming 65536 invalid blocks → count stays 16'hFFFF.
- Assert rst while in TWO with tx_ready = 0 → tx_block_valid = 0 and in_ready = 0 immediately. After release, the first block is scrambled from SEED.
- With PCS_TX_SCR_BYPASS_EN: scr_bypass = 1 for a block in the middle of a stream → that block's payload is unchanged, and the next scrambled block continues as if the bypassed block were absent.
